// File: rtl/line_cmd_tx.sv
// line_cmd_tx: UART (8N1) sender of one display-line frame: 'L', row byte, then RAM payload bytes.
// Latency: first start bit 1 cycle after accepted start; 10*UART_TICKS_PER_BIT cycles per byte, 2-cycle RAM fetch gap per payload byte.
// Backpressure: none; start is only accepted in IDLE and is dropped while busy. Option: LINE_CMD_TX_CHECKSUM_EN appends an XOR checksum byte.
module line_cmd_tx #(
    parameter int UART_TICKS_PER_BIT_SIZE = 7,
    parameter logic [UART_TICKS_PER_BIT_SIZE-1:0] UART_TICKS_PER_BIT = 7'd65,
    parameter int PAYLOAD_BYTES = 64,
    parameter int ADDR_WIDTH    = 12,
    parameter int ROW_WIDTH     = 5
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ROW_WIDTH-1:0]  row,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_read_en,
    input  logic [7:0]            ram_data_in,
    output logic                  busy,
    output logic                  done,
    output logic                  tx_out
);

    localparam int TW = UART_TICKS_PER_BIT_SIZE;
    localparam int IW = $clog2(PAYLOAD_BYTES + 1);
    localparam logic [TW-1:0] TICK_LAST = UART_TICKS_PER_BIT - TW'(1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(PAYLOAD_BYTES - 1);
    localparam logic [7:0]    CMD_BYTE  = 8'h4C;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        ROW   = 3'd2,
        FETCH = 3'd3,
        DATA  = 3'd4,
        CSUM  = 3'd5,
        FIN   = 3'd6
    } state_t;

    state_t                state, state_next;
    logic [TW-1:0]         tick;
    logic [3:0]            bit_cnt;
    logic [7:0]            shift;
    logic [IW-1:0]         idx;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ROW_WIDTH-1:0]  row_q;
    logic                  fetch_ph;
    logic                  bit_end;
    logic                  byte_end;
    logic                  last_byte;
    logic [7:0]            row_byte;
`ifdef LINE_CMD_TX_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    assign bit_end   = (tick == TICK_LAST);
    assign byte_end  = bit_end && (bit_cnt == 4'd9);
    assign last_byte = (idx == IDX_LAST);
    assign row_byte  = 8'(row_q);

    // State register.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state sequencing and status decode; busy drops in FIN alongside done.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = CMD;
            end
            CMD: begin
                busy = 1'b1;
                if (byte_end) state_next = ROW;
            end
            ROW: begin
                busy = 1'b1;
                if (byte_end) state_next = FETCH;
            end
            FETCH: begin
                busy = 1'b1;
                if (fetch_ph) state_next = DATA;
            end
            DATA: begin
                busy = 1'b1;
                if (byte_end) begin
                    if (!last_byte) begin
                        state_next = FETCH;
                    end else begin
`ifdef LINE_CMD_TX_CHECKSUM_EN
                        state_next = CSUM;
`else
                        state_next = FIN;
`endif
                    end
                end
            end
            CSUM: begin
                busy = 1'b1;
                if (byte_end) state_next = FIN;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Serializer, payload fetch and frame bookkeeping; each new byte's start bit is
    // driven on the same edge that ends the previous stop bit so bytes run back-to-back.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            tx_out      <= 1'b1;
            ram_read_en <= 1'b0;
            ram_address <= '0;
            tick        <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            idx         <= '0;
            base_q      <= '0;
            row_q       <= '0;
            fetch_ph    <= 1'b0;
`ifdef LINE_CMD_TX_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            ram_read_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        row_q   <= row;
                        idx     <= '0;
                        shift   <= CMD_BYTE;
                        tx_out  <= 1'b0;
                        tick    <= '0;
                        bit_cnt <= '0;
                    end
                end
                FETCH: begin
                    // Phase 0 is the read-strobe cycle; data is on ram_data_in in phase 1.
                    if (!fetch_ph) begin
                        fetch_ph <= 1'b1;
                    end else begin
                        fetch_ph <= 1'b0;
                        shift    <= ram_data_in;
                        tx_out   <= 1'b0;
                        tick     <= '0;
                        bit_cnt  <= '0;
`ifdef LINE_CMD_TX_CHECKSUM_EN
                        csum     <= csum ^ ram_data_in;
`endif
                    end
                end
                CMD, ROW, DATA, CSUM: begin
                    if (!bit_end) begin
                        tick <= tick + TW'(1);
                    end else begin
                        tick <= '0;
                        if (bit_cnt != 4'd9) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd8) begin
                                tx_out <= 1'b1;
                            end else begin
                                tx_out <= shift[0];
                                shift  <= {1'b0, shift[7:1]};
                            end
                        end else begin
                            bit_cnt <= '0;
                            if (state == DATA) idx <= idx + IW'(1);
                            case (state_next)
                                ROW: begin
                                    shift  <= row_byte;
                                    tx_out <= 1'b0;
`ifdef LINE_CMD_TX_CHECKSUM_EN
                                    csum   <= row_byte;
`endif
                                end
                                FETCH: begin
                                    ram_read_en <= 1'b1;
                                    ram_address <= base_q + ADDR_WIDTH'((state == DATA) ? idx + IW'(1) : idx);
                                    fetch_ph    <= 1'b0;
                                end
`ifdef LINE_CMD_TX_CHECKSUM_EN
                                CSUM: begin
                                    shift  <= csum;
                                    tx_out <= 1'b0;
                                end
`endif
                                default: ;
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
